// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
// Frame FSM states, prefix bytes and keyb_char field positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int VALID_BIT = 31;
    localparam int ERR_BIT   = 11;
    localparam int OVF_BIT   = 10;
    localparam int EXT_BIT   = 9;
    localparam int BRK_BIT   = 8;

    localparam int ENTRY_W = 10;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO holding {ext, brk, code} key events.
// Tracks a sticky overflow flag for pushes dropped while full.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    // A pop frees a slot, so a push into a full FIFO is accepted alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pin sync, frame FSM, watchdog and prefix folding.
// Presents the oldest key event as the CPU-visible keyb_char word.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    output logic [31:0] keyb_char,
    output logic        empty,
    output logic        full
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_q1, clk_q2, clk_q3;
    logic dat_q1, dat_q2;
    logic fall;

    ps2_state_t state, state_next;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout;
    logic            frame_done;
    logic            frame_ok;

    logic         ext, brk, err;
    logic         good, bad, is_prefix;
    logic         push;
    logic [ENTRY_W-1:0] head;
    logic         ovf;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_q1 <= 1'b1;
            clk_q2 <= 1'b1;
            clk_q3 <= 1'b1;
            dat_q1 <= 1'b1;
            dat_q2 <= 1'b1;
        end else begin
            clk_q1 <= ps2_clk;
            clk_q2 <= clk_q1;
            clk_q3 <= clk_q2;
            dat_q1 <= ps2_data;
            dat_q2 <= dat_q1;
        end
    end

    assign fall    = clk_q3 & ~clk_q2;
    assign timeout = (state != IDLE) && (wd_cnt >= WD_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        frame_ok   = 1'b0;
        if (timeout) begin
            state_next = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE:   if (!dat_q2) state_next = DATA;
                DATA:   if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                    frame_ok   = dat_q2 & (^{shreg, par_bit});
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE || fall)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (fall && !timeout) begin
                unique case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shreg   <= {dat_q2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_bit <= dat_q2;
                    STOP:   ;
                endcase
            end
        end
    end

    assign good      = frame_done & frame_ok;
    assign bad       = frame_done & ~frame_ok;
    assign is_prefix = (shreg == PS2_EXT) || (shreg == PS2_BRK);
    assign push      = good & ~is_prefix;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext <= 1'b0;
            brk <= 1'b0;
            err <= 1'b0;
        end else if (bad) begin
            ext <= 1'b0;
            brk <= 1'b0;
            err <= 1'b1;
        end else if (good) begin
            if (shreg == PS2_EXT) begin
                ext <= 1'b1;
            end else if (shreg == PS2_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (rd_en),
        .din      ({ext, brk, shreg}),
        .dout     (head),
        .empty    (empty),
        .full     (full),
        .overflow (ovf)
    );

    // Storage is not cleared on reset, so the event fields are masked when empty.
    always_comb begin
        keyb_char            = '0;
        keyb_char[VALID_BIT] = ~empty;
        keyb_char[ERR_BIT]   = err;
        keyb_char[OVF_BIT]   = ovf;
        if (!empty)
            keyb_char[EXT_BIT:0] = head;
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames driven on the pins,
// keyb_char/empty/full compared against hand-computed words.
module tb_ps2_scancode_rx;

    localparam int HALF = 20;
    localparam int TMO  = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        rd_en = 1'b0;
    logic [31:0] keyb_char;
    logic        empty;
    logic        full;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ps2_scancode_rx #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .keyb_char (keyb_char),
        .empty     (empty),
        .full      (full)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] code,
                                          input logic flip);
        return {1'b1, (~^code) ^ flip, code, 1'b0};
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // pop_last pulses rd_en on exactly the clk edge that registers the push
    task automatic send_bits(input logic [10:0] f, input int n,
                             input bit pop_last);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            wait_neg(HALF);
            ps2_clk = 1'b0;
            if (pop_last && i == n - 1) begin
                wait_neg(2);
                rd_en = 1'b1;
                wait_neg(1);
                rd_en = 1'b0;
                wait_neg(HALF - 3);
            end else begin
                wait_neg(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_code(input logic [7:0] code, input logic flip);
        send_bits(frame(code, flip), 11, 1'b0);
        wait_neg(2 * HALF);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        wait_neg(1);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_neg(3);
        reset = 1'b1;
        wait_neg(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        wait_neg(3);
        check("rst_word", keyb_char, 32'h0000_0000);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        reset = 1'b1;
        wait_neg(2);

        send_code(8'h1C, 1'b0);
        check("make_1c", keyb_char, 32'h8000_001C);
        check("make_1c_empty", 32'(empty), 32'd0);
        pop();
        check("pop_1c", keyb_char, 32'h0000_0000);
        check("pop_1c_empty", 32'(empty), 32'd1);
        pop();
        check("pop_underflow", keyb_char, 32'h0000_0000);

        send_code(8'hE0, 1'b0);
        check("e0_no_push", 32'(empty), 32'd1);
        send_code(8'hF0, 1'b0);
        send_code(8'h75, 1'b0);
        check("ext_brk_75", keyb_char, 32'h8000_0375);
        pop();
        check("ext_brk_one", 32'(empty), 32'd1);
        send_code(8'h75, 1'b0);
        check("plain_75", keyb_char, 32'h8000_0075);
        pop();

        send_code(8'h1C, 1'b1);
        check("par_err", keyb_char, 32'h0000_0800);
        send_code(8'h1C, 1'b0);
        check("par_err_then_1c", keyb_char, 32'h8000_081C);
        pop();

        do_reset();
        check("rst_clears_err", keyb_char, 32'h0000_0000);
        for (int i = 1; i <= 9; i++)
            send_code(8'(i), 1'b0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_head", keyb_char, 32'h8000_0401);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_rd%0d", i), keyb_char,
                  32'h8000_0400 | 32'(i));
            pop();
        end
        check("ovf_drained", keyb_char, 32'h0000_0400);
        check("ovf_drained_empty", 32'(empty), 32'd1);

        do_reset();
        for (int i = 1; i <= 8; i++)
            send_code(8'(i), 1'b0);
        check("pp_full_before", 32'(full), 32'd1);
        send_bits(frame(8'h09, 1'b0), 11, 1'b1);
        wait_neg(2 * HALF);
        check("pp_full_after", 32'(full), 32'd1);
        check("pp_head", keyb_char, 32'h8000_0002);
        for (int i = 2; i <= 9; i++) begin
            check($sformatf("pp_rd%0d", i), keyb_char,
                  32'h8000_0000 | 32'(i));
            pop();
        end
        check("pp_drained", keyb_char, 32'h0000_0000);

        do_reset();
        send_bits(frame(8'h29, 1'b0), 5, 1'b0);
        wait_neg(TMO + 40);
        check("tmo_nothing", 32'(empty), 32'd1);
        send_code(8'h29, 1'b0);
        check("tmo_then_29", keyb_char, 32'h8000_0029);

        send_code(8'h1C, 1'b0);
        send_bits(frame(8'h5A, 1'b0), 3, 1'b0);
        reset = 1'b0;
        wait_neg(1);
        check("midrst_word", keyb_char, 32'h0000_0000);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_full", 32'(full), 32'd0);
        reset = 1'b1;
        wait_neg(2);
        send_code(8'h1C, 1'b0);
        check("after_rst_1c", keyb_char, 32'h8000_001C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
